// File: rtl/core_fetch_unit.sv
// Instruction fetch and PC sequencing for the RV32I front end.
// It runs one outstanding word fetch at a time and has a one-entry skid register behind the decode buffer.
module core_fetch_unit #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] brj_pc_i,
  input  logic                  stall_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instr_pc_o,
  output logic                  flush_o
);

  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [DATA_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                  discard_q, discard_d;
  logic                  req_q, req_d;
  logic                  valid_q, valid_d;

  logic                  consume;
  logic [DATA_WIDTH-1:0] target;
  logic [DATA_WIDTH-1:0] fetch_next;
  logic [DATA_WIDTH-1:0] skid_next;

  assign consume    = valid_q & ~stall_i;
  assign target     = brj_pc_i & ~(DATA_WIDTH'(PC_STEP - 1));
  assign fetch_next = fetch_pc_q + DATA_WIDTH'(PC_STEP);
  assign skid_next  = skid_pc_q + DATA_WIDTH'(PC_STEP);

  // Next-state logic; a redirect at the end overrides the normal sequencing.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_pc_d  = fetch_pc_q;
    addr_d      = addr_q;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    discard_d   = discard_q;
    req_d       = req_q;
    valid_d     = valid_q;

    if (consume) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        req_d   = 1'b1;
        addr_d  = pc_q;
      end
      S_REQ: begin
        if (imem_gnt_i) begin
          fetch_pc_d = addr_q;
          req_d      = 1'b0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          if (discard_q) begin
            discard_d = 1'b0;
            req_d     = 1'b1;
            addr_d    = pc_q;
            state_d   = S_REQ;
          end else if (!valid_q || consume) begin
            valid_d    = 1'b1;
            instr_d    = imem_rdata_i;
            instr_pc_d = fetch_pc_q;
            pc_d       = fetch_next;
            addr_d     = fetch_next;
            req_d      = 1'b1;
            state_d    = S_REQ;
          end else begin
            skid_data_d = imem_rdata_i;
            skid_pc_d   = fetch_pc_q;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (consume) begin
          valid_d    = 1'b1;
          instr_d    = skid_data_q;
          instr_pc_d = skid_pc_q;
          pc_d       = skid_next;
          addr_d     = skid_next;
          req_d      = 1'b1;
          state_d    = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase

    if (redirect_i) begin
      pc_d    = target;
      valid_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          addr_d = target;
        end
        // A pending request keeps its address; its response is dropped later.
        S_REQ: begin
          discard_d = 1'b1;
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            discard_d = 1'b0;
            req_d     = 1'b1;
            addr_d    = target;
            state_d   = S_REQ;
          end else begin
            discard_d = 1'b1;
          end
        end
        S_HOLD: begin
          req_d   = 1'b1;
          addr_d  = target;
          state_d = S_REQ;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      fetch_pc_q  <= '0;
      addr_q      <= RESET_PC;
      skid_data_q <= '0;
      skid_pc_q   <= '0;
      instr_q     <= '0;
      instr_pc_q  <= '0;
      discard_q   <= 1'b0;
      req_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_pc_q  <= fetch_pc_d;
      addr_q      <= addr_d;
      skid_data_q <= skid_data_d;
      skid_pc_q   <= skid_pc_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      discard_q   <= discard_d;
      req_q       <= req_d;
      valid_q     <= valid_d;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign flush_o       = redirect_i;

endmodule

// File: tb/tb_core_fetch_unit.sv
// Bench for core_fetch_unit: a randomised memory responder drives the design, and an in-order program-flow model checks it.
// The model expects each buffered instruction at the next sequential PC or at the last redirect target.
module tb_core_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rstn;
  logic        redirect_i;
  logic [31:0] brj_pc_i;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        flush_o;

  core_fetch_unit #(.DATA_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .redirect_i   (redirect_i),
    .brj_pc_i     (brj_pc_i),
    .stall_i      (stall_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_valid_o(instr_valid_o),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .flush_o      (flush_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_pc;
  bit          hash_mode;
  bit          gnt_en;
  int          lat_lo;
  int          lat_hi;
  bit          mem_busy;
  logic [31:0] mem_addr;
  int          mem_delay;
  int          idle_cnt;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (hash_mode) return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    return 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: answer the fetch port, check the buffer against the model, advance the memory.
  task automatic tick();
    logic        s_gnt;
    logic        s_rv;
    logic [31:0] s_addr;
    imem_gnt_i    = imem_req_o & gnt_en;
    imem_rvalid_i = mem_busy && (mem_delay == 0);
    imem_rdata_i  = imem_rvalid_i ? memfn(mem_addr) : 32'hDEAD_BEEF;
    #1;
    chk("flush", 32'(flush_o), 32'(redirect_i));
    chk("addr_align", 32'(imem_addr_o[1:0]), 32'd0);
    chk("req_while_busy", 32'(imem_req_o & mem_busy), 32'd0);
    if (instr_valid_o) begin
      chk("instr_pc", instr_pc_o, exp_pc);
      chk("instr", instr_o, memfn(exp_pc));
    end
    if (redirect_i) begin
      exp_pc   = brj_pc_i & ~32'h3;
      idle_cnt = 0;
    end else if (instr_valid_o && !stall_i) begin
      exp_pc   = exp_pc + 32'd4;
      idle_cnt = 0;
    end else begin
      idle_cnt++;
    end
    if (idle_cnt >= 100) begin
      chk("watchdog", 32'(idle_cnt), 32'd0);
      idle_cnt = 0;
    end
    s_gnt  = imem_gnt_i;
    s_rv   = imem_rvalid_i;
    s_addr = imem_addr_o;
    @(posedge clk);
    if (s_rv) mem_busy = 1'b0;
    else if (mem_busy && mem_delay > 0) mem_delay--;
    if (s_gnt) begin
      mem_busy  = 1'b1;
      mem_addr  = s_addr;
      mem_delay = int'($urandom_range(lat_hi, lat_lo));
    end
    @(negedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!imem_req_o && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(imem_req_o), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(instr_valid_o), 32'd1);
  endtask

  initial begin
    rstn = 1'b0; redirect_i = 1'b0; brj_pc_i = '0; stall_i = 1'b0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    gnt_en = 1'b1; lat_lo = 0; lat_hi = 0; hash_mode = 1'b0;
    mem_busy = 1'b0; mem_addr = '0; mem_delay = 0; idle_cnt = 0;
    exp_pc = RST_PC;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_addr", imem_addr_o, RST_PC);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_instr_pc", instr_pc_o, 32'd0);
    rstn = 1'b1;

    // Always-grant nop memory: the buffer fills one cycle in two.
    tick();
    chk("first_req", 32'(imem_req_o), 32'd1);
    chk("first_addr", imem_addr_o, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("valid_alt", 32'(instr_valid_o), 32'((k % 2) == 0));
    end
    chk("pc8_shown", instr_pc_o, 32'h8);
    chk("req_c_addr", imem_addr_o, 32'hC);

    // Stall for five cycles: 0xC lands in the skid register and 0x10 is not requested.
    stall_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_no_req", 32'(imem_req_o), 32'd0);
      chk("stall_hold_pc", instr_pc_o, 32'h8);
    end
    stall_i = 1'b0;
    lat_lo = 2; lat_hi = 2;
    tick();
    chk("skid_pc", instr_pc_o, 32'hC);
    chk("req_10", imem_addr_o, 32'h10);
    tick();
    chk("wait_no_req", 32'(imem_req_o), 32'd0);

    // Redirect while waiting for a response with no rvalid this cycle.
    redirect_i = 1'b1; brj_pc_i = 32'h103;
    tick();
    redirect_i = 1'b0; brj_pc_i = '0;
    wait_req("redir_wait_req");
    chk("redir_wait_addr", imem_addr_o, 32'h100);
    lat_lo = 0; lat_hi = 0;
    wait_valid("v100");
    chk("pc_100", instr_pc_o, 32'h100);
    chk("addr_104", imem_addr_o, 32'h104);

    // Redirect in REQ with grant held low for three cycles.
    gnt_en = 1'b0;
    redirect_i = 1'b1; brj_pc_i = 32'h200;
    tick();
    redirect_i = 1'b0; brj_pc_i = '0;
    chk("hold_req", 32'(imem_req_o), 32'd1);
    chk("hold_addr", imem_addr_o, 32'h104);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("hold_req", 32'(imem_req_o), 32'd1);
      chk("hold_addr", imem_addr_o, 32'h104);
    end
    gnt_en = 1'b1;
    tick();
    wait_req("redir_req_req");
    chk("redir_req_addr", imem_addr_o, 32'h200);
    wait_valid("v200");
    chk("pc_200", instr_pc_o, 32'h200);

    // Redirect together with stall clears a live buffer.
    redirect_i = 1'b1; stall_i = 1'b1; brj_pc_i = 32'h300;
    tick();
    redirect_i = 1'b0; stall_i = 1'b0; brj_pc_i = '0;
    chk("redir_stall_clear", 32'(instr_valid_o), 32'd0);
    wait_valid("v300");
    chk("pc_300", instr_pc_o, 32'h300);

    // PC wrap; the low target bits must be ignored.
    redirect_i = 1'b1; brj_pc_i = 32'hFFFF_FFFF;
    tick();
    redirect_i = 1'b0; brj_pc_i = '0;
    wait_valid("vwrap");
    chk("pc_fffc", instr_pc_o, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr_o, 32'h0);
    tick();
    wait_valid("v0");
    chk("pc_0", instr_pc_o, 32'h0);

    // Asynchronous reset mid-fetch, followed by a stray response during IDLE.
    rstn = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req_o), 32'd0);
    chk("arst_valid", 32'(instr_valid_o), 32'd0);
    chk("arst_addr", imem_addr_o, RST_PC);
    mem_busy = 1'b1; mem_delay = 0; mem_addr = 32'h40;
    hash_mode = 1'b1; exp_pc = RST_PC; idle_cnt = 0;
    @(negedge clk);
    #1;
    rstn = 1'b1;
    tick();
    chk("post_rst_req", 32'(imem_req_o), 32'd1);
    chk("post_rst_addr", imem_addr_o, RST_PC);

    // Random traffic: stalls, redirects, grant gaps and variable latency.
    lat_lo = 0; lat_hi = 3;
    for (int k = 0; k < 3000; k++) begin
      stall_i    = ($urandom % 4) == 0;
      redirect_i = ($urandom % 20) == 0;
      brj_pc_i   = $urandom;
      gnt_en     = ($urandom % 4) != 0;
      tick();
    end
    redirect_i = 1'b0; stall_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
